keypad_ctrl: RTL and testbench
==============================

KEYPAD_CTRL -- requirements
Module: keypad_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 16'd50000, number of consecutive stable clk cycles required to accept a key press or a key release; legal range 1..65535.
REQ-002 Parameter MAX_DIGITS, default 3, maximum BCD digits per operand; legal range 1..4.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 key_da  input  1  data-available from keypad encoder; high while a key is held.
REQ-006 key_code  input  4  decoded key: 4'h0-4'h9 digits, 4'hA-4'hD operators D/C/B/A, 4'hE '#', 4'hF '*'.
REQ-007 out_ready  input  1  downstream accepts the current entry when high with out_valid.
REQ-008 out_valid  output  1  completed entry (operand + operator) available.
REQ-009 out_operand  output  16  BCD operand, least significant digit in [3:0], unused digits zero.
REQ-010 out_op  output  4  operator key code (4'hA-4'hE) that terminated the entry.
REQ-011 digit_cnt  output  3  digits currently held in the entry buffer.
REQ-012 key_pulse  output  1  one-cycle strobe per accepted (debounced) key.

Function
REQ-013 The block SHALL implement states IDLE, DEBOUNCE, PROCESS, EMIT, RELEASE.
REQ-014 IDLE: key_da=1 -> DEBOUNCE with debounce counter cleared; otherwise remain.
REQ-015 DEBOUNCE: counter increments each cycle key_da=1; key_da=0 at any count -> IDLE, no key accepted; counter reaching DB_CYCLES-1 with key_da=1 -> PROCESS.
REQ-016 PROCESS (exactly one cycle): key_code SHALL be sampled in this cycle and key_pulse SHALL be high in this cycle only.
REQ-017 Digit key, digit_cnt<MAX_DIGITS: buffer shifts left one nibble, new digit enters [3:0], digit_cnt increments; next state RELEASE.
REQ-018 Digit key, digit_cnt=MAX_DIGITS: digit discarded, buffer and digit_cnt unchanged; next state RELEASE.
REQ-019 '*' (4'hF): buffer and digit_cnt cleared to zero; no entry emitted; next state RELEASE.
REQ-020 Operator key (4'hA-4'hE): out_operand loaded from buffer, out_op loaded from key_code, out_valid set, buffer and digit_cnt cleared; next state EMIT. Operator with digit_cnt=0 SHALL emit operand 0.
REQ-021 EMIT: out_valid, out_operand, out_op held stable until the cycle out_valid=1 and out_ready=1; out_valid SHALL drop the following cycle; next state RELEASE.
REQ-022 RELEASE: counter increments each cycle key_da=0, clears when key_da=1; reaching DB_CYCLES-1 with key_da=0 -> IDLE. A held key SHALL never produce a second key_pulse.
REQ-023 key_da activity during EMIT SHALL be ignored; no key is captured until the FSM returns to IDLE.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Counter width 16 bits, saturating never required since it clears on every transition into DEBOUNCE/RELEASE.
REQ-026 key_code SHALL be ignored in all states other than PROCESS.

Reset
REQ-027 rst_n=0 on a rising edge SHALL force state IDLE, counter 0, buffer 0, digit_cnt 0, out_valid 0, out_operand 0, out_op 0, key_pulse 0, regardless of current state, including mid-DEBOUNCE and mid-EMIT.
REQ-028 A pending entry in EMIT SHALL be discarded by reset, not delivered after reset release.
REQ-029 A key still held at reset release SHALL be accepted only after a full DEBOUNCE from IDLE.

Verification (DB_CYCLES=4, MAX_DIGITS=3)
REQ-030 Press '1','2','3', then 'A' (4'hD), out_ready=1 -> one key_pulse per key; out_operand=16'h0123, out_op=4'hD, out_valid high exactly one cycle.
REQ-031 key_da high 2 cycles then low (bounce) -> no key_pulse, state back to IDLE, digit_cnt=0.
REQ-032 Press '9','8','7','6' then '#' -> fourth digit dropped; out_operand=16'h0987, out_op=4'hE.
REQ-033 Press '5','*','7', then 'B' (4'hC) -> out_operand=16'h0007, out_op=4'hC.
REQ-034 Emit with out_ready=0 for 10 cycles while key '4' pressed -> outputs stable, '4' not captured; out_ready=1 -> out_valid drops next cycle, digit_cnt=0.
REQ-035 Press '3', assert rst_n=0 mid-DEBOUNCE of next key -> all outputs zero, digit_cnt=0, next entry starts from empty buffer.

Source files
------------

// File: rtl/keypad_ctrl.sv
// Keypad entry controller: debounces key presses/releases, accumulates BCD digits
// and emits operand + operator when an operator key terminates the entry.
module keypad_ctrl #(
    parameter logic [15:0] DB_CYCLES  = 16'd50000,
    parameter int          MAX_DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_da,
    input  logic [3:0]  key_code,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_operand,
    output logic [3:0]  out_op,
    output logic [2:0]  digit_cnt,
    output logic        key_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        PROCESS,
        EMIT,
        RELEASE
    } state_t;

    localparam logic [15:0] DB_LAST   = DB_CYCLES - 16'd1;
    localparam logic [2:0]  DIGIT_MAX = 3'(MAX_DIGITS);

    state_t      state;
    state_t      state_next;
    logic [15:0] db_cnt;
    logic [15:0] buffer;
    logic        is_digit;
    logic        is_op;
    logic        is_clear;

    assign is_digit = (key_code <= 4'h9);
    assign is_op    = (key_code >= 4'hA) && (key_code <= 4'hE);
    assign is_clear = (key_code == 4'hF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (key_da) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!key_da) begin
                    state_next = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_next = PROCESS;
                end
            end
            PROCESS: begin
                state_next = is_op ? EMIT : RELEASE;
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!key_da && (db_cnt == DB_LAST)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        key_pulse = (state == PROCESS);
    end

    // Counter is zeroed on every path into DEBOUNCE and RELEASE, so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt      <= 16'd0;
            buffer      <= 16'd0;
            digit_cnt   <= 3'd0;
            out_valid   <= 1'b0;
            out_operand <= 16'd0;
            out_op      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    db_cnt <= 16'd0;
                end
                DEBOUNCE: begin
                    if (key_da) begin
                        db_cnt <= db_cnt + 16'd1;
                    end
                end
                PROCESS: begin
                    db_cnt <= 16'd0;
                    if (is_digit) begin
                        if (digit_cnt < DIGIT_MAX) begin
                            buffer    <= {buffer[11:0], key_code};
                            digit_cnt <= digit_cnt + 3'd1;
                        end
                    end else if (is_clear) begin
                        buffer    <= 16'd0;
                        digit_cnt <= 3'd0;
                    end else if (is_op) begin
                        out_operand <= buffer;
                        out_op      <= key_code;
                        out_valid   <= 1'b1;
                        buffer      <= 16'd0;
                        digit_cnt   <= 3'd0;
                    end
                end
                EMIT: begin
                    db_cnt <= 16'd0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (key_da) begin
                        db_cnt <= 16'd0;
                    end else begin
                        db_cnt <= db_cnt + 16'd1;
                    end
                end
                default: begin
                    db_cnt <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl with a short debounce window (DB_CYCLES=4, MAX_DIGITS=3).
module tb_keypad_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_da;
    logic [3:0]  key_code;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_operand;
    logic [3:0]  out_op;
    logic [2:0]  digit_cnt;
    logic        key_pulse;

    int vectors = 0;
    int errors  = 0;
    int pulse_cnt = 0;
    int valid_cycles = 0;
    logic [15:0] last_operand = 16'd0;
    logic [3:0]  last_op = 4'd0;

    typedef struct {
        logic [3:0]  key;
        logic [2:0]  exp_digits;
        logic        emits;
        logic [15:0] exp_operand;
        logic [3:0]  exp_op;
    } vec_t;

    vec_t vecs[14];

    keypad_ctrl #(.DB_CYCLES(16'd4), .MAX_DIGITS(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_da(key_da),
        .key_code(key_code),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_operand(out_operand),
        .out_op(out_op),
        .digit_cnt(digit_cnt),
        .key_pulse(key_pulse)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer of strobes and delivered entries.
    always @(negedge clk) begin
        if (key_pulse === 1'b1) pulse_cnt++;
        if (out_valid === 1'b1) begin
            valid_cycles++;
            last_operand = out_operand;
            last_op      = out_op;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] key, input int hold, input int rel);
        key_code = key;
        key_da   = 1'b1;
        repeat (hold) tick();
        key_da   = 1'b0;
        key_code = 4'h8;
        repeat (rel) tick();
    endtask

    initial begin
        int p0;
        int v0;

        vecs[0]  = '{4'h1, 3'd1, 1'b0, 16'h0000, 4'h0};
        vecs[1]  = '{4'h2, 3'd2, 1'b0, 16'h0000, 4'h0};
        vecs[2]  = '{4'h3, 3'd3, 1'b0, 16'h0000, 4'h0};
        vecs[3]  = '{4'hD, 3'd0, 1'b1, 16'h0123, 4'hD};
        vecs[4]  = '{4'h9, 3'd1, 1'b0, 16'h0000, 4'h0};
        vecs[5]  = '{4'h8, 3'd2, 1'b0, 16'h0000, 4'h0};
        vecs[6]  = '{4'h7, 3'd3, 1'b0, 16'h0000, 4'h0};
        vecs[7]  = '{4'h6, 3'd3, 1'b0, 16'h0000, 4'h0};
        vecs[8]  = '{4'hE, 3'd0, 1'b1, 16'h0987, 4'hE};
        vecs[9]  = '{4'h5, 3'd1, 1'b0, 16'h0000, 4'h0};
        vecs[10] = '{4'hF, 3'd0, 1'b0, 16'h0000, 4'h0};
        vecs[11] = '{4'h7, 3'd1, 1'b0, 16'h0000, 4'h0};
        vecs[12] = '{4'hC, 3'd0, 1'b1, 16'h0007, 4'hC};
        vecs[13] = '{4'hA, 3'd0, 1'b1, 16'h0000, 4'hA};

        rst_n = 1'b0;
        key_da = 1'b0;
        key_code = 4'h0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_operand", 32'(out_operand), 32'd0);
        checkOutput("reset out_op", 32'(out_op), 32'd0);
        checkOutput("reset digit_cnt", 32'(digit_cnt), 32'd0);
        checkOutput("reset key_pulse", 32'(key_pulse), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            p0 = pulse_cnt;
            v0 = valid_cycles;
            applyStimulus(vecs[i].key, 7, 8);
            checkOutput($sformatf("vec%0d pulses", i), 32'(pulse_cnt - p0), 32'd1);
            checkOutput($sformatf("vec%0d digit_cnt", i), 32'(digit_cnt), 32'(vecs[i].exp_digits));
            checkOutput($sformatf("vec%0d valid cycles", i), 32'(valid_cycles - v0), 32'(vecs[i].emits));
            if (vecs[i].emits) begin
                checkOutput($sformatf("vec%0d operand", i), 32'(last_operand), 32'(vecs[i].exp_operand));
                checkOutput($sformatf("vec%0d op", i), 32'(last_op), 32'(vecs[i].exp_op));
            end
        end

        // Short bounce is rejected; a long hold yields a single key.
        p0 = pulse_cnt;
        key_code = 4'h2;
        key_da = 1'b1;
        repeat (2) tick();
        key_da = 1'b0;
        repeat (6) tick();
        checkOutput("bounce pulses", 32'(pulse_cnt - p0), 32'd0);
        checkOutput("bounce digit_cnt", 32'(digit_cnt), 32'd0);
        applyStimulus(4'h1, 30, 8);
        checkOutput("held key pulses", 32'(pulse_cnt - p0), 32'd1);
        checkOutput("held key digit_cnt", 32'(digit_cnt), 32'd1);

        // Stalled emit with key activity that must be ignored.
        out_ready = 1'b0;
        p0 = pulse_cnt;
        applyStimulus(4'hA, 7, 2);
        key_code = 4'h4;
        key_da = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d operand", i), 32'(out_operand), 32'h0001);
            checkOutput($sformatf("stall%0d op", i), 32'(out_op), 32'hA);
        end
        key_da = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("handshake drop", 32'(out_valid), 32'd0);
        checkOutput("handshake digit_cnt", 32'(digit_cnt), 32'd0);
        repeat (8) tick();
        checkOutput("stall pulses", 32'(pulse_cnt - p0), 32'd1);
        checkOutput("stall key ignored", 32'(digit_cnt), 32'd0);

        // Reset while an entry waits in EMIT discards it.
        applyStimulus(4'h2, 7, 8);
        out_ready = 1'b0;
        applyStimulus(4'hB, 7, 2);
        checkOutput("pre-reset valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("emit reset valid", 32'(out_valid), 32'd0);
        checkOutput("emit reset operand", 32'(out_operand), 32'd0);
        checkOutput("emit reset op", 32'(out_op), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        v0 = valid_cycles;
        repeat (10) tick();
        checkOutput("no late delivery", 32'(valid_cycles - v0), 32'd0);

        // Reset mid-debounce with the key still held afterwards.
        applyStimulus(4'h3, 7, 8);
        checkOutput("pre-reset digit_cnt", 32'(digit_cnt), 32'd1);
        p0 = pulse_cnt;
        key_code = 4'h5;
        key_da = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("deb reset digit_cnt", 32'(digit_cnt), 32'd0);
        checkOutput("deb reset key_pulse", 32'(key_pulse), 32'd0);
        checkOutput("deb reset out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        repeat (7) tick();
        key_da = 1'b0;
        repeat (8) tick();
        checkOutput("held through reset pulses", 32'(pulse_cnt - p0), 32'd1);
        checkOutput("held through reset digit_cnt", 32'(digit_cnt), 32'd1);
        v0 = valid_cycles;
        applyStimulus(4'hD, 7, 8);
        checkOutput("post-reset valid cycles", 32'(valid_cycles - v0), 32'd1);
        checkOutput("post-reset operand", 32'(last_operand), 32'h0005);
        checkOutput("post-reset op", 32'(last_op), 32'hD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
